// File: rtl/led_pattern_engine.sv
// LED pattern engine: programmable prescaler driving rotate-left, rotate-right,
// bounce and binary-count patterns, with seed load and run/pause control.
module led_pattern_engine #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 24,
  parameter int SPD_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [SPD_W-1:0] speed_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] led_o,
  output logic             step_o
);

  localparam logic [1:0] MODE_ROTL  = 2'b00;
  localparam logic [1:0] MODE_ROTR  = 2'b01;
  localparam logic [1:0] MODE_BNCE  = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Terminal count 2^min(s,DIV_W)-1 as a mask of the low s bits; speeds at or
  // beyond DIV_W saturate to all ones, which gives the clamp for free.
  function automatic logic [DIV_W-1:0] term_mask(input logic [SPD_W-1:0] spd);
    logic [DIV_W-1:0] m;
    m = '0;
    for (int i = 0; i < DIV_W; i++) begin
      m[i] = (i < int'(spd)) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  logic [WIDTH-1:0] led_q, led_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             hit_s;
  logic [WIDTH-1:0] pat_s;
  logic             pat_dir_s;

  // ">=" rather than "==" so lowering the speed mid-period steps at once.
  assign hit_s = en_i && (div_q >= term_mask(speed_i));

  // Pattern value and bounce direction that a step would produce this cycle.
  always_comb begin
    pat_s     = led_q;
    pat_dir_s = dir_q;
    case (mode_i)
      MODE_ROTL:  pat_s = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      MODE_ROTR:  pat_s = {led_q[0], led_q[WIDTH-1:1]};
      MODE_BNCE: begin
        // Turn around on the step that would push the lit bit off the end,
        // so the end position is shown once and never repeated.
        if (dir_q == DIR_LEFT) begin
          if (led_q[WIDTH-1]) begin
            pat_dir_s = DIR_RIGHT;
            pat_s     = {1'b0, led_q[WIDTH-1:1]};
          end else begin
            pat_s     = {led_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (led_q[0]) begin
            pat_dir_s = DIR_LEFT;
            pat_s     = {led_q[WIDTH-2:0], 1'b0};
          end else begin
            pat_s     = {1'b0, led_q[WIDTH-1:1]};
          end
        end
      end
      MODE_COUNT: pat_s = led_q + WIDTH'(1);
      default:    pat_s = led_q;
    endcase
  end

  // Next-state selection: seed load beats a step, pause freezes everything.
  always_comb begin
    led_d  = led_q;
    div_d  = div_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (load_i) begin
      led_d  = seed_i;
      div_d  = '0;
      dir_d  = DIR_LEFT;
      step_d = 1'b0;
    end else if (hit_s) begin
      led_d  = pat_s;
      dir_d  = pat_dir_s;
      div_d  = '0;
      step_d = 1'b1;
    end else if (en_i) begin
      div_d  = div_q + DIV_W'(1);
    end else begin
      div_d  = div_q;
    end
  end

  // State registers; reset lights only the LSB and clears the prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q  <= WIDTH'(1);
      div_q  <= '0;
      dir_q  <= DIR_LEFT;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      div_q  <= div_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign led_o  = led_q;
  assign step_o = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed self-checking bench for led_pattern_engine at WIDTH=8.
module tb_led_pattern_engine;

  logic       clk;
  logic       rst;
  logic       en_i;
  logic [1:0] mode_i;
  logic [4:0] speed_i;
  logic       load_i;
  logic [7:0] seed_i;
  logic [7:0] led_o;
  logic       step_o;

  int tests;
  int fails;

  logic [7:0] exp_led;
  logic [7:0] bounce_seq [15];

  led_pattern_engine #(.WIDTH(8), .DIV_W(24), .SPD_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .speed_i (speed_i),
    .load_i  (load_i),
    .seed_i  (seed_i),
    .led_o   (led_o),
    .step_o  (step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    rst = 1'b1; en_i = 1'b0; mode_i = 2'b00; speed_i = 5'd0;
    load_i = 1'b0; seed_i = 8'h00;

    // Reset state
    tick(); tick();
    chk("reset_led", 32'(led_o), 32'h01);
    chk("reset_step", 32'(step_o), 32'h0);
    rst = 1'b0;

    // Rotate left at s=0: step every clock, wraps 80 -> 01
    en_i = 1'b1;
    exp_led = 8'h01;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_led = {exp_led[6:0], exp_led[7]};
      chk("rotl_led", 32'(led_o), 32'(exp_led));
      chk("rotl_step", 32'(step_o), 32'h1);
    end
    chk("rotl_wrap", 32'(led_o), 32'h01);

    // Rotate right at s=2: one step per 4 clocks
    mode_i = 2'b01; speed_i = 5'd2;
    exp_led = 8'h01;
    for (int k = 0; k < 12; k++) begin
      tick();
      if ((k % 4) == 3) begin
        exp_led = {exp_led[0], exp_led[7:1]};
        chk("rotr_step", 32'(step_o), 32'h1);
      end else begin
        chk("rotr_nostep", 32'(step_o), 32'h0);
      end
      chk("rotr_led", 32'(led_o), 32'(exp_led));
    end
    chk("rotr_final", 32'(led_o), 32'h20);

    // Bounce from seed 01 at s=0; load suppresses step
    mode_i = 2'b10; speed_i = 5'd0; seed_i = 8'h01; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    chk("bnc_load_led", 32'(led_o), 32'h01);
    chk("bnc_load_step", 32'(step_o), 32'h0);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("bnc_led", 32'(led_o), 32'(bounce_seq[k]));
      chk("bnc_step", 32'(step_o), 32'h1);
    end

    // Count mode from FE: FF, 00, 01
    mode_i = 2'b11; seed_i = 8'hFE; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    chk("cnt_load", 32'(led_o), 32'hFE);
    tick(); chk("cnt_ff", 32'(led_o), 32'hFF); chk("cnt_step0", 32'(step_o), 32'h1);
    tick(); chk("cnt_wrap", 32'(led_o), 32'h00); chk("cnt_step1", 32'(step_o), 32'h1);
    tick(); chk("cnt_01", 32'(led_o), 32'h01); chk("cnt_step2", 32'(step_o), 32'h1);

    // Zero seed in rotate mode holds zero while stepping
    mode_i = 2'b00; seed_i = 8'h00; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick(); chk("zero_rot_led", 32'(led_o), 32'h00); chk("zero_rot_step", 32'(step_o), 32'h1);

    // s=3 pause with div_cnt at 5 (five enabled edges after load)
    speed_i = 5'd3; seed_i = 8'h01; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_pause_led", 32'(led_o), 32'h01);
    en_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("pause_led", 32'(led_o), 32'h01);
      chk("pause_step", 32'(step_o), 32'h0);
    end
    en_i = 1'b1;
    // div_cnt 5 -> 6 -> 7, step on the edge that sees 7
    tick(); chk("resume_n1", 32'(step_o), 32'h0);
    tick(); chk("resume_n2", 32'(step_o), 32'h0);
    tick(); chk("resume_step", 32'(step_o), 32'h1); chk("resume_led", 32'(led_o), 32'h02);

    // Load A5 on the edge that would have stepped
    for (int k = 0; k < 7; k++) tick();
    chk("preload_led", 32'(led_o), 32'h02);
    seed_i = 8'hA5; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    chk("ld_step_led", 32'(led_o), 32'hA5);
    chk("ld_step_step", 32'(step_o), 32'h0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("ld_gap_step", 32'(step_o), 32'h0);
    end
    tick();
    chk("ld_next_step", 32'(step_o), 32'h1);
    chk("ld_next_led", 32'(led_o), 32'h4B);

    // Async reset between edges right after a step
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_led", 32'(led_o), 32'h01);
    chk("arst_step", 32'(step_o), 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("post_rst_nostep", 32'(step_o), 32'h0);
    end
    tick();
    chk("post_rst_step", 32'(step_o), 32'h1);
    chk("post_rst_led", 32'(led_o), 32'h02);

    // Speed drop s=10 -> 1 with div_cnt=300 steps on the next clock
    speed_i = 5'd10;
    for (int k = 0; k < 300; k++) tick();
    chk("slow_nostep", 32'(step_o), 32'h0);
    chk("slow_led", 32'(led_o), 32'h02);
    speed_i = 5'd1;
    tick();
    chk("spd_drop_step", 32'(step_o), 32'h1);
    chk("spd_drop_led", 32'(led_o), 32'h04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
